// File: rtl/psg_phase_sequencer_if.sv
// rtl/psg_phase_sequencer_if.sv - phase word stream from sequencer to PSG sine path
//
// Signals:
//   m_phase_d   phase word (two's complement, full scale = 2*pi)
//   m_phase_ch  channel index of the phase word
//   m_phase_dv  valid
//   m_phase_dr  ready (driven by the PSG)
//   m_zero      channel disabled; meaningful only while m_phase_dv is high
// Modports: master (sequencer side), slave (PSG side).
interface psg_phase_sequencer_if #(
    parameter int PHASE_WIDTH = 24,
    parameter int CHW         = 2
);
    logic [PHASE_WIDTH-1:0] m_phase_d;
    logic [CHW-1:0]         m_phase_ch;
    logic                   m_phase_dv;
    logic                   m_phase_dr;
    logic                   m_zero;

    modport master (
        output m_phase_d,
        output m_phase_ch,
        output m_phase_dv,
        output m_zero,
        input  m_phase_dr
    );

    modport slave (
        input  m_phase_d,
        input  m_phase_ch,
        input  m_phase_dv,
        input  m_zero,
        output m_phase_dr
    );
endinterface

// File: rtl/psg_phase_sequencer.sv
// rtl/psg_phase_sequencer.sv - per-sample phase scheduler feeding the PSG sine path
//
// Holds one phase accumulator, increment and enable per channel. Each
// sample_tick issues one phase word per channel in channel order over m_phase.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   sample_tick      one-cycle pulse starting a sequence
//   cfg_wr/cfg_ch    configuration write strobe and target channel
//   cfg_incr/cfg_en  increment and enable written to cfg_ch
//   cfg_phase_rst    zero the target accumulator on write
//   m_phase          phase stream master (psg_phase_sequencer_if.master)
//   busy             sequence in progress
//   overrun          sticky: tick arrived while busy; overrun_clr clears it
//
// Optional build macro: PSG_PHASE_SEQ_SKIP_DISABLED_EN
//   defined   - disabled channels are skipped without a transfer, m_zero tied 0
//   undefined - every channel is issued on each tick
module psg_phase_sequencer #(
    parameter int  NR_CHANNELS = 3,
    parameter int  PHASE_WIDTH = 24,
    localparam int CHW         = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_tick,
    input  logic                       cfg_wr,
    input  logic [CHW-1:0]             cfg_ch,
    input  logic [PHASE_WIDTH-1:0]     cfg_incr,
    input  logic                       cfg_en,
    input  logic                       cfg_phase_rst,
    psg_phase_sequencer_if.master      m_phase,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       overrun_clr
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state, state_nxt;
    logic [CHW-1:0]         ch_cnt, ch_nxt;
    logic [PHASE_WIDTH-1:0] acc  [NR_CHANNELS];
    logic [PHASE_WIDTH-1:0] incr [NR_CHANNELS];
    logic [NR_CHANNELS-1:0] en;

    logic                   hs;
    logic                   last;
    logic                   has_first, has_next;
    logic [CHW-1:0]         first_ch, next_ch;
    logic [PHASE_WIDTH-1:0] sel_d;
`ifndef PSG_PHASE_SEQ_SKIP_DISABLED_EN
    logic                   sel_en;
`endif

    // Channel search: first channel to issue on a tick, and the channel that
    // follows ch_cnt within the current sequence.
    always_comb begin
`ifdef PSG_PHASE_SEQ_SKIP_DISABLED_EN
        has_first = 1'b0;
        first_ch  = '0;
        has_next  = 1'b0;
        next_ch   = '0;
        // Descending scan so the lowest matching index is the one kept.
        for (int i = NR_CHANNELS - 1; i >= 0; i--) begin
            if (en[i]) begin
                has_first = 1'b1;
                first_ch  = CHW'(i);
            end
            if (en[i] && (i > int'(ch_cnt))) begin
                has_next = 1'b1;
                next_ch  = CHW'(i);
            end
        end
`else
        has_first = 1'b1;
        first_ch  = '0;
        has_next  = (int'(ch_cnt) < NR_CHANNELS - 1);
        next_ch   = ch_cnt + CHW'(1);
`endif
    end

    assign hs   = (state == SEND) && m_phase.m_phase_dr;
    assign last = hs && !has_next;

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch_cnt;
        case (state)
            IDLE: begin
                if (sample_tick && has_first) begin
                    state_nxt = SEND;
                    ch_nxt    = first_ch;
                end
            end
            SEND: begin
                if (hs) begin
                    if (has_next) begin
                        ch_nxt = next_ch;
                    end else if (sample_tick && has_first) begin
                        // Tick on the final handshake restarts without a gap.
                        ch_nxt = first_ch;
                    end else begin
                        state_nxt = IDLE;
                        ch_nxt    = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                ch_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ch_cnt <= '0;
        end else begin
            state  <= state_nxt;
            ch_cnt <= ch_nxt;
        end
    end

    // A tick during SEND that is not absorbed by a final handshake is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (sample_tick && (state == SEND) && !last) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Per-channel state. Out-of-range cfg_ch matches no channel and is ignored.
    // Phase reset has priority over the handshake update; the update uses the
    // increment and enable held before any same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
                acc[i]  <= '0;
                incr[i] <= '0;
            end
            en <= '0;
        end else begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
                if (cfg_wr && (cfg_ch == CHW'(i))) begin
                    incr[i] <= cfg_incr;
                    en[i]   <= cfg_en;
                end
                if (cfg_wr && (cfg_ch == CHW'(i)) && cfg_phase_rst) begin
                    acc[i] <= '0;
                end else if (hs && (ch_cnt == CHW'(i)) && en[i]) begin
                    acc[i] <= acc[i] + incr[i];
                end
            end
        end
    end

    always_comb begin
        sel_d  = '0;
`ifndef PSG_PHASE_SEQ_SKIP_DISABLED_EN
        sel_en = 1'b0;
`endif
        for (int i = 0; i < NR_CHANNELS; i++) begin
            if (ch_cnt == CHW'(i)) begin
                sel_d  = acc[i];
`ifndef PSG_PHASE_SEQ_SKIP_DISABLED_EN
                sel_en = en[i];
`endif
            end
        end
    end

    assign m_phase.m_phase_d  = sel_d;
    assign m_phase.m_phase_ch = ch_cnt;
    assign m_phase.m_phase_dv = (state == SEND);
`ifdef PSG_PHASE_SEQ_SKIP_DISABLED_EN
    assign m_phase.m_zero     = 1'b0;
`else
    assign m_phase.m_zero     = ~sel_en;
`endif
    assign busy = (state == SEND);
endmodule

// File: tb/tb_psg_phase_sequencer.sv
// tb/tb_psg_phase_sequencer.sv - scoreboard bench for psg_phase_sequencer
module tb_psg_phase_sequencer;
`ifdef PSG_PHASE_SEQ_SKIP_DISABLED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        sample_tick;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [23:0] cfg_incr;
    logic        cfg_en;
    logic        cfg_phase_rst;
    logic        busy;
    logic        overrun;
    logic        overrun_clr;

    psg_phase_sequencer_if #(.PHASE_WIDTH(24), .CHW(2)) phase_if ();

    psg_phase_sequencer #(.NR_CHANNELS(3), .PHASE_WIDTH(24)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .cfg_wr        (cfg_wr),
        .cfg_ch        (cfg_ch),
        .cfg_incr      (cfg_incr),
        .cfg_en        (cfg_en),
        .cfg_phase_rst (cfg_phase_rst),
        .m_phase       (phase_if),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [23:0] d;
        logic        zero;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [23:0] d, input logic zero);
        exp_t x;
        x.ch   = ch;
        x.d    = d;
        x.zero = SKIP ? 1'b0 : zero;
        q.push_back(x);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [23:0] inc, input logic en, input logic prst);
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_ch = ch; cfg_incr = inc; cfg_en = en; cfg_phase_rst = prst;
        @(posedge clk); #1;
        cfg_wr = 1'b0; cfg_phase_rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
            else n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: got busy expected idle within 200 cycles");
        end
    endtask

    // Monitor: every handshake pops one expected word.
    always @(negedge clk) begin
        if (rst_n && phase_if.m_phase_dv && phase_if.m_phase_dr) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got ch=%0d d=%h expected no transfer",
                         phase_if.m_phase_ch, phase_if.m_phase_d);
            end else begin
                e = q.pop_front();
                if (phase_if.m_phase_ch !== e.ch || phase_if.m_phase_d !== e.d ||
                    phase_if.m_zero !== e.zero) begin
                    fails++;
                    $display("FAIL sb_word: got ch=%0d d=%h z=%b expected ch=%0d d=%h z=%b",
                             phase_if.m_phase_ch, phase_if.m_phase_d, phase_if.m_zero,
                             e.ch, e.d, e.zero);
                end
            end
        end
    end

    logic [23:0] ch0_wrap [5];

    initial begin
        int n;
        ch0_wrap[0] = 24'h000000;
        ch0_wrap[1] = 24'h400000;
        ch0_wrap[2] = 24'h800000;
        ch0_wrap[3] = 24'hC00000;
        ch0_wrap[4] = 24'h000000;

        rst_n = 1'b1; sample_tick = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_incr = '0;
        cfg_en = 1'b0; cfg_phase_rst = 1'b0; overrun_clr = 1'b0;
        phase_if.m_phase_dr = 1'b1;
        #3 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_dv", 32'(phase_if.m_phase_dv), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_ch", 32'(phase_if.m_phase_ch), 0);
        chk("rst_d", 32'(phase_if.m_phase_d), 0);
        chk("rst_zero", 32'(phase_if.m_zero), SKIP ? 0 : 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic sequence
        cfg(2'd0, 24'h000100, 1'b1, 1'b0);
        cfg(2'd1, 24'h000200, 1'b1, 1'b0);
        cfg(2'd2, 24'h000300, 1'b1, 1'b0);
        push(0, 24'h0, 0); push(1, 24'h0, 0); push(2, 24'h0, 0);
        tick();
        chk("latency_dv", 32'(phase_if.m_phase_dv), 1);
        wait_idle(n);
        chk("seq_len", 32'(n), 3);
        push(0, 24'h100, 0); push(1, 24'h200, 0); push(2, 24'h300, 0);
        tick();
        wait_idle(n);

        // Wrap on ch0
        cfg(2'd0, 24'h400000, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            push(0, ch0_wrap[k], 0);
            push(1, 24'(32'h400 + k * 32'h200), 0);
            push(2, 24'(32'h600 + k * 32'h300), 0);
            tick();
            wait_idle(n);
        end

        // Backpressure on ch1
        cfg(2'd0, 24'h000100, 1'b1, 1'b1);
        cfg(2'd1, 24'h000200, 1'b1, 1'b1);
        cfg(2'd2, 24'h000300, 1'b1, 1'b1);
        phase_if.m_phase_dr = 1'b0;
        push(0, 24'h0, 0); push(1, 24'h0, 0); push(2, 24'h0, 0);
        tick();
        @(negedge clk);
        chk("bp_ch0_hold", 32'(phase_if.m_phase_ch), 0);
        @(posedge clk); #1 phase_if.m_phase_dr = 1'b1;
        @(posedge clk); #1 phase_if.m_phase_dr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_dv", 32'(phase_if.m_phase_dv), 1);
            chk("bp_ch", 32'(phase_if.m_phase_ch), 1);
            chk("bp_d", 32'(phase_if.m_phase_d), 0);
        end
        @(posedge clk); #1 phase_if.m_phase_dr = 1'b1;
        wait_idle(n);

        // Overrun and back-to-back restart
        phase_if.m_phase_dr = 1'b0;
        push(0, 24'h100, 0); push(1, 24'h200, 0); push(2, 24'h300, 0);
        tick();
        tick();
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_busy", 32'(busy), 1);
        chk("ovr_ch", 32'(phase_if.m_phase_ch), 0);
        @(posedge clk); #1 overrun_clr = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);
        push(0, 24'h200, 0); push(1, 24'h400, 0); push(2, 24'h600, 0);
        @(posedge clk); #1 phase_if.m_phase_dr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        chk("restart_busy", 32'(busy), 1);
        chk("restart_ch", 32'(phase_if.m_phase_ch), 0);
        chk("restart_ovr", 32'(overrun), 0);
        wait_idle(n);

        // Disable ch1, phase reset ch0 during its handshake
        cfg(2'd1, 24'h000200, 1'b0, 1'b0);
        push(0, 24'h300, 0);
        if (!SKIP) push(1, 24'h600, 1);
        push(2, 24'h900, 0);
        tick();
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_incr = 24'h000100; cfg_en = 1'b1; cfg_phase_rst = 1'b1;
        @(posedge clk); #1 cfg_wr = 1'b0; cfg_phase_rst = 1'b0;
        wait_idle(n);
        push(0, 24'h0, 0);
        if (!SKIP) push(1, 24'h600, 1);
        push(2, 24'hC00, 0);
        tick();
        wait_idle(n);
        chk("dis_seq_len", 32'(n), SKIP ? 2 : 3);

        // Asynchronous reset mid-sequence
        phase_if.m_phase_dr = 1'b0;
        tick();
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dv", 32'(phase_if.m_phase_dv), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_d", 32'(phase_if.m_phase_d), 0);
        chk("arst_ch", 32'(phase_if.m_phase_ch), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        phase_if.m_phase_dr = 1'b1;
        cfg(2'd0, 24'h000010, 1'b1, 1'b0);
        cfg(2'd1, 24'h000010, 1'b1, 1'b0);
        cfg(2'd2, 24'h000010, 1'b1, 1'b0);
        push(0, 24'h0, 0); push(1, 24'h0, 0); push(2, 24'h0, 0);
        tick();
        wait_idle(n);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
